// File: rtl/tt_div_pkg.sv
// Shared types and pin-map constants for the TT10 serial divider tile.
package tt_div_pkg;

  localparam int unsigned WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // uio_in control bit positions
  localparam int unsigned LOAD_A_BIT  = 0;
  localparam int unsigned LOAD_B_BIT  = 1;
  localparam int unsigned START_BIT   = 2;
  localparam int unsigned SEL_REM_BIT = 3;

  // uio_out status bit positions
  localparam int unsigned BUSY_BIT = 4;
  localparam int unsigned DONE_BIT = 5;
  localparam int unsigned DBZ_BIT  = 6;

  localparam logic [7:0] UIO_OE_MASK = 8'hF0;

endpackage

// File: rtl/tt_div_if.sv
// Tile pin bundle: operand/control inputs and result/status outputs.
interface tt_div_if;
  import tt_div_pkg::*;

  logic             ena;
  logic [WIDTH-1:0] ui_in;
  logic [7:0]       uio_in;
  logic [WIDTH-1:0] uo_out;
  logic [7:0]       uio_out;
  logic [7:0]       uio_oe;

  modport master (
    output ena, ui_in, uio_in,
    input  uo_out, uio_out, uio_oe
  );

  modport slave (
    input  ena, ui_in, uio_in,
    output uo_out, uio_out, uio_oe
  );
endinterface

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract.
module div_step
  import tt_div_pkg::*;
(
  input  logic [WIDTH:0]   rem_acc,
  input  logic [WIDTH-1:0] quo_sh,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_next,
  output logic [WIDTH-1:0] quo_next
);

  localparam int unsigned RW = WIDTH + 1;

  logic [WIDTH+1:0] rem_sh;
  logic [WIDTH+1:0] diff;
  logic             fits;

  // Extra top bit keeps the compare exact; rem_acc[WIDTH] is always 0 between steps.
  always_comb begin
    rem_sh   = {rem_acc, quo_sh[WIDTH-1]};
    diff     = rem_sh - {2'b00, divisor};
    fits     = (rem_sh >= {2'b00, divisor});
    rem_next = fits ? RW'(diff) : RW'(rem_sh);
    quo_next = {quo_sh[WIDTH-2:0], fits};
  end

endmodule

// File: rtl/tt_um_serial_divider_tt10_digitallogic.sv
// Sequential 8-bit unsigned restoring divider: FSM, operand/result registers, pin mapping.
module tt_um_serial_divider_tt10_digitallogic
  import tt_div_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [WIDTH-1:0] ui_in,
  input  logic [7:0]       uio_in,
  output logic [WIDTH-1:0] uo_out,
  output logic [7:0]       uio_out,
  output logic [7:0]       uio_oe
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  state_t           state;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH:0]   rem_acc;
  logic [WIDTH-1:0] quo_sh;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] q_res;
  logic [WIDTH-1:0] r_res;
  logic             done;
  logic             div_by_zero;

  logic [WIDTH:0]   rem_next;
  logic [WIDTH-1:0] quo_next;

  logic load_a, load_b, start, sel_rem, any_load;
  assign load_a   = uio_in[LOAD_A_BIT];
  assign load_b   = uio_in[LOAD_B_BIT];
  assign start    = uio_in[START_BIT];
  assign sel_rem  = uio_in[SEL_REM_BIT];
  assign any_load = load_a | load_b;

  div_step u_step (
    .rem_acc  (rem_acc),
    .quo_sh   (quo_sh),
    .divisor  (divisor),
    .rem_next (rem_next),
    .quo_next (quo_next)
  );

  // Loads take priority over start; both are ignored while RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      dividend    <= '0;
      divisor     <= '0;
      rem_acc     <= '0;
      quo_sh      <= '0;
      cnt         <= '0;
      q_res       <= '0;
      r_res       <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (any_load) begin
            if (load_a) dividend <= ui_in;
            if (load_b) divisor  <= ui_in;
            if (state == DONE) begin
              done        <= 1'b0;
              div_by_zero <= 1'b0;
              state       <= IDLE;
            end
          end else if (start) begin
            if (divisor == '0) begin
              q_res       <= '1;
              r_res       <= dividend;
              done        <= 1'b1;
              div_by_zero <= 1'b1;
              state       <= DONE;
            end else begin
              quo_sh      <= dividend;
              rem_acc     <= '0;
              cnt         <= '0;
              done        <= 1'b0;
              div_by_zero <= 1'b0;
              state       <= RUN;
            end
          end
        end
        RUN: begin
          rem_acc <= rem_next;
          quo_sh  <= quo_next;
          cnt     <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) begin
            q_res       <= quo_next;
            r_res       <= WIDTH'(rem_next);
            done        <= 1'b1;
            div_by_zero <= 1'b0;
            state       <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign uo_out = sel_rem ? r_res : q_res;

  always_comb begin
    uio_out           = '0;
    uio_out[BUSY_BIT] = (state == RUN);
    uio_out[DONE_BIT] = done;
    uio_out[DBZ_BIT]  = div_by_zero;
  end

  assign uio_oe = UIO_OE_MASK;

  logic unused;
  assign unused = &{1'b0, ena, uio_in[7:4]};

endmodule

// File: tb/tb_tt_um_serial_divider_tt10_digitallogic.sv
// Scoreboard bench for the serial divider tile.
module tb_tt_um_serial_divider_tt10_digitallogic;
  import tt_div_pkg::*;

  typedef struct packed {
    logic [7:0] q;
    logic [7:0] r;
    logic       dbz;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];
  logic [7:0] m_a = '0;
  logic [7:0] m_b = '0;

  tt_div_if bus ();

  tt_um_serial_divider_tt10_digitallogic dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (bus.ena),
    .ui_in   (bus.ui_in),
    .uio_in  (bus.uio_in),
    .uo_out  (bus.uo_out),
    .uio_out (bus.uio_out),
    .uio_oe  (bus.uio_oe)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic load_op(input bit is_b, input logic [7:0] v);
    logic [7:0] c;
    c = '0;
    if (is_b) c[LOAD_B_BIT] = 1'b1;
    else      c[LOAD_A_BIT] = 1'b1;
    bus.ui_in  = v;
    bus.uio_in = c;
    step();
    bus.uio_in = '0;
    if (is_b) m_b = v;
    else      m_a = v;
  endtask

  task automatic push_expect();
    exp_t e;
    if (m_b == 8'd0) e = '{q: 8'hFF, r: m_a, dbz: 1'b1};
    else             e = '{q: m_a / m_b, r: m_a % m_b, dbz: 1'b0};
    sb.push_back(e);
  endtask

  // Start a division, optionally poke load_a+start during RUN, then score the result.
  task automatic run_div(input string tag, input int poke_at);
    logic [7:0] c;
    int   n;
    int   busy_n;
    exp_t e;
    n = 0;
    busy_n = 0;
    push_expect();
    e = sb[$];
    c = '0;
    c[START_BIT] = 1'b1;
    bus.uio_in = c;
    step();
    bus.uio_in = '0;
    check({tag, "_done_at_start"}, 32'(bus.uio_out[DONE_BIT]), 32'(e.dbz));
    while (!bus.uio_out[DONE_BIT] && n < 20) begin
      if (bus.uio_out[BUSY_BIT]) busy_n++;
      if (n == poke_at) begin
        c = '0;
        c[LOAD_A_BIT] = 1'b1;
        c[START_BIT]  = 1'b1;
        bus.ui_in  = 8'd9;
        bus.uio_in = c;
        step();
        bus.uio_in = '0;
      end else begin
        step();
      end
      n++;
    end
    check({tag, "_timeout"}, 32'(n < 20), 32'd1);
    check({tag, "_busy_cycles"}, 32'(busy_n), e.dbz ? 32'd0 : 32'd8);
    e = sb.pop_front();
    bus.uio_in[SEL_REM_BIT] = 1'b0;
    #1;
    check({tag, "_quo"}, 32'(bus.uo_out), 32'(e.q));
    bus.uio_in[SEL_REM_BIT] = 1'b1;
    #1;
    check({tag, "_rem"}, 32'(bus.uo_out), 32'(e.r));
    bus.uio_in[SEL_REM_BIT] = 1'b0;
    check({tag, "_dbz"}, 32'(bus.uio_out[DBZ_BIT]), 32'(e.dbz));
    check({tag, "_busy_end"}, 32'(bus.uio_out[BUSY_BIT]), 32'd0);
  endtask

  initial begin
    logic [7:0] c;
    bus.ena    = 1'b1;
    bus.ui_in  = '0;
    bus.uio_in = '0;
    rst_n      = 1'b0;
    step();
    step();
    check("rst_uo_out", 32'(bus.uo_out), 32'd0);
    check("rst_uio_out", 32'(bus.uio_out), 32'd0);
    check("rst_uio_oe", 32'(bus.uio_oe), 32'hF0);
    rst_n = 1'b1;
    step();

    load_op(1'b0, 8'd200);
    load_op(1'b1, 8'd7);
    run_div("d200_7", -1);

    load_op(1'b0, 8'd255);
    load_op(1'b1, 8'd1);
    run_div("d255_1", -1);
    load_op(1'b0, 8'd3);
    check("load_clears_done", 32'(bus.uio_out[DONE_BIT]), 32'd0);
    load_op(1'b1, 8'd10);
    run_div("d3_10", -1);

    load_op(1'b0, 8'd5);
    load_op(1'b1, 8'd0);
    run_div("d5_0", -1);

    load_op(1'b0, 8'd200);
    load_op(1'b1, 8'd7);
    run_div("poke_run", 2);
    run_div("poke_rerun", -1);

    // Async reset mid-RUN with a prior result still held
    c = '0;
    c[START_BIT] = 1'b1;
    bus.uio_in = c;
    step();
    bus.uio_in = '0;
    step();
    step();
    step();
    rst_n = 1'b0;
    #1;
    check("midrun_rst_uo_out", 32'(bus.uo_out), 32'd0);
    check("midrun_rst_uio_out", 32'(bus.uio_out), 32'd0);
    bus.uio_in[SEL_REM_BIT] = 1'b1;
    #1;
    check("midrun_rst_rem", 32'(bus.uo_out), 32'd0);
    bus.uio_in[SEL_REM_BIT] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    m_a = '0;
    m_b = '0;
    run_div("post_rst_cleared", -1);
    load_op(1'b0, 8'd130);
    load_op(1'b1, 8'd130);
    run_div("d130_130", -1);

    // Load beats start in the same cycle
    load_op(1'b0, 8'd100);
    load_op(1'b1, 8'd6);
    c = '0;
    c[LOAD_B_BIT] = 1'b1;
    c[START_BIT]  = 1'b1;
    bus.ui_in  = 8'd3;
    bus.uio_in = c;
    step();
    bus.uio_in = '0;
    m_b = 8'd3;
    check("ld_st_busy", 32'(bus.uio_out[BUSY_BIT]), 32'd0);
    step();
    check("ld_st_busy_late", 32'(bus.uio_out[BUSY_BIT]), 32'd0);
    run_div("d100_3", -1);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
